// File: rtl/reaction_game_ctrl_if.sv
// Signal bundle between the reaction game controller, its time counter and the
// player-facing buttons, switches and LEDs.
interface reaction_game_ctrl_if;
  logic       qsec;
  logic       go;
  logic       stop;
  logic [3:0] target;
  logic [3:0] time_bits;
  logic       time_rst;
  logic       run_led;
  logic       win_led;
  logic       lose_led;
  logic [3:0] score;
  logic [3:0] last_time;

  modport master (
    output qsec, go, stop, target, time_bits,
    input  time_rst, run_led, win_led, lose_led, score, last_time
  );

  modport slave (
    input  qsec, go, stop, target, time_bits,
    output time_rst, run_led, win_led, lose_led, score, last_time
  );
endinterface

// File: rtl/reaction_game_ctrl.sv
// "Stop at the target second" game controller: arms the time counter on go,
// judges the stop press, keeps a saturating win score and flashes the result.
module reaction_game_ctrl #(
  parameter int unsigned HOLD_SEC    = 2,
  parameter int unsigned TIMEOUT_SEC = 15
) (
  input logic                 clk,
  input logic                 rst_n,
  reaction_game_ctrl_if.slave game_io
);

  localparam logic [3:0] HoldVal    = 4'(HOLD_SEC);
  localparam logic [3:0] TimeoutVal = 4'(TIMEOUT_SEC);

  typedef enum logic [1:0] {StIdle, StRun, StWin, StLose} state_e;

  state_e     state_q, state_d;
  logic       go_prev_q, stop_prev_q;
  logic       time_rst_q, time_rst_d;
  logic       blink_q, blink_d;
  logic       armed_q, armed_d;
  logic [3:0] score_q, score_d;
  logic [3:0] last_time_q, last_time_d;
  logic [3:0] target_q, target_d;
  logic       go_rise, stop_rise, in_result;

  assign go_rise   = game_io.go & ~go_prev_q;
  assign stop_rise = game_io.stop & ~stop_prev_q;
  assign in_result = (state_q == StWin) || (state_q == StLose);

  always_comb begin
    state_d     = state_q;
    score_d     = score_q;
    last_time_d = last_time_q;
    target_d    = target_q;
    unique case (state_q)
      StIdle: begin
        if (go_rise) begin
          state_d  = StRun;
          target_d = game_io.target;
        end
      end
      StRun: begin
        // Stop wins over a simultaneous timeout and is judged on the live time.
        if (stop_rise) begin
          last_time_d = game_io.time_bits;
          if (game_io.time_bits == target_q) begin
            state_d = StWin;
            score_d = (score_q == 4'd15) ? score_q : score_q + 4'd1;
          end else begin
            state_d = StLose;
          end
        end else if (game_io.time_bits == TimeoutVal) begin
          state_d     = StLose;
          last_time_d = TimeoutVal;
        end
      end
      StWin, StLose: begin
        // armed masks the first cycle, where time_bits still shows the RUN value.
        if (armed_q && (game_io.time_bits >= HoldVal)) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    time_rst_d = (state_d == StIdle) || ((state_q == StRun) && (state_d != StRun));
    armed_d    = in_result && (state_d == state_q);
    blink_d    = in_result ? (game_io.qsec ? ~blink_q : blink_q) : 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      go_prev_q   <= 1'b1;
      stop_prev_q <= 1'b1;
      time_rst_q  <= 1'b1;
      blink_q     <= 1'b1;
      armed_q     <= 1'b0;
      score_q     <= 4'd0;
      last_time_q <= 4'd0;
      target_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      go_prev_q   <= game_io.go;
      stop_prev_q <= game_io.stop;
      time_rst_q  <= time_rst_d;
      blink_q     <= blink_d;
      armed_q     <= armed_d;
      score_q     <= score_d;
      last_time_q <= last_time_d;
      target_q    <= target_d;
    end
  end

  assign game_io.time_rst  = time_rst_q;
  assign game_io.run_led   = (state_q == StRun);
  assign game_io.win_led   = (state_q == StWin) & blink_q;
  assign game_io.lose_led  = (state_q == StLose) & blink_q;
  assign game_io.score     = score_q;
  assign game_io.last_time = last_time_q;

endmodule

// File: tb/tb_reaction_game_ctrl.sv
// Directed bench for reaction_game_ctrl; models the quarter-second time counter
// (qsec every other cycle, seconds saturating at 15, cleared by time_rst).
module tb_reaction_game_ctrl;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;
  int   exp_score;

  logic [1:0] qcnt;
  logic [3:0] sec;

  reaction_game_ctrl_if game_if();

  reaction_game_ctrl #(
    .HOLD_SEC   (2),
    .TIMEOUT_SEC(15)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .game_io(game_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // One clock: advance the counter model from what it sees before the edge.
  task automatic step();
    logic [1:0] nq;
    logic [3:0] ns;
    nq = qcnt;
    ns = sec;
    if (game_if.time_rst) begin
      nq = 2'd0;
      ns = 4'd0;
    end else if (game_if.qsec) begin
      if (qcnt == 2'd3) begin
        nq = 2'd0;
        if (sec != 4'd15) ns = sec + 4'd1;
      end else begin
        nq = qcnt + 2'd1;
      end
    end
    @(posedge clk);
    #1;
    qcnt = nq;
    sec  = ns;
    game_if.time_bits = sec;
    game_if.qsec      = ~game_if.qsec;
  endtask

  task automatic press_go();
    game_if.go = 1'b0;
    step();
    game_if.go = 1'b1;
    step();
    game_if.go = 1'b0;
  endtask

  task automatic wait_sec(input logic [3:0] s);
    for (int i = 0; i < 300 && game_if.time_bits != s; i++) step();
    check_eq("wait_sec", {4'd0, game_if.time_bits}, {4'd0, s});
  endtask

  task automatic wait_idle();
    logic [3:0] prev;
    logic       done;
    prev = 4'd0;
    done = 1'b0;
    for (int i = 0; i < 400 && !done; i++) begin
      prev = game_if.time_bits;
      step();
      if (game_if.time_rst && !game_if.win_led && !game_if.lose_led && !game_if.run_led)
        done = 1'b1;
    end
    check_eq("idle_reached", {7'd0, done}, 8'd1);
    check_eq("exit_sec", {4'd0, prev}, 8'd2);
  endtask

  task automatic play(input logic [3:0] tgt, input logic [3:0] stop_at, input logic exp_win,
                      input logic [3:0] exp_sc);
    game_if.target = tgt;
    press_go();
    check_eq("run_led", {7'd0, game_if.run_led}, 8'd1);
    wait_sec(stop_at);
    game_if.stop = 1'b1;
    step();
    game_if.stop = 1'b0;
    check_eq("play_win", {7'd0, game_if.win_led}, {7'd0, exp_win});
    check_eq("play_lose", {7'd0, game_if.lose_led}, {7'd0, ~exp_win});
    check_eq("play_score", {4'd0, game_if.score}, {4'd0, exp_sc});
    check_eq("play_last", {4'd0, game_if.last_time}, {4'd0, stop_at});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_time_rst"}, {7'd0, game_if.time_rst}, 8'd1);
    check_eq({tag, "_leds"}, {5'd0, game_if.run_led, game_if.win_led, game_if.lose_led}, 8'd0);
    check_eq({tag, "_score"}, {4'd0, game_if.score}, 8'd0);
    check_eq({tag, "_last"}, {4'd0, game_if.last_time}, 8'd0);
  endtask

  initial begin
    logic exp_led;
    n_vec = 0;
    n_err = 0;
    qcnt  = 2'd0;
    sec   = 4'd0;
    rst_n = 1'b0;
    game_if.go        = 1'b1;
    game_if.stop      = 1'b0;
    game_if.target    = 4'd0;
    game_if.qsec      = 1'b0;
    game_if.time_bits = 4'd0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // go held through reset must not start a round; stop in IDLE is ignored
    for (int i = 0; i < 3; i++) step();
    check_eq("go_held", {7'd0, game_if.run_led}, 8'd0);
    game_if.stop = 1'b1;
    step();
    game_if.stop = 1'b0;
    step();
    check_eq("idle_stop", {6'd0, game_if.run_led, game_if.lose_led}, 8'd0);

    // Round 1: target 5, stop at 5, target switched after capture
    game_if.target = 4'd5;
    press_go();
    check_eq("r1_run", {7'd0, game_if.run_led}, 8'd1);
    check_eq("r1_trst", {7'd0, game_if.time_rst}, 8'd0);
    game_if.target = 4'd7;
    wait_sec(4'd5);
    game_if.stop = 1'b1;
    step();
    game_if.stop = 1'b0;
    check_eq("r1_win", {7'd0, game_if.win_led}, 8'd1);
    check_eq("r1_trst_pulse", {7'd0, game_if.time_rst}, 8'd1);
    check_eq("r1_score", {4'd0, game_if.score}, 8'd1);
    check_eq("r1_last", {4'd0, game_if.last_time}, 8'd5);
    for (int i = 0; i < 4; i++) begin
      exp_led = game_if.qsec ? ~game_if.win_led : game_if.win_led;
      step();
      check_eq("r1_blink", {7'd0, game_if.win_led}, {7'd0, exp_led});
      if (i == 0) check_eq("r1_trst_low", {7'd0, game_if.time_rst}, 8'd0);
    end
    wait_idle();

    // Round 2: stop one second early
    play(4'd5, 4'd4, 1'b0, 4'd1);
    wait_idle();

    // Round 3: no stop, timeout at 15
    game_if.target = 4'd3;
    press_go();
    wait_sec(4'd15);
    step();
    check_eq("r3_lose", {7'd0, game_if.lose_led}, 8'd1);
    check_eq("r3_last", {4'd0, game_if.last_time}, 8'd15);
    check_eq("r3_score", {4'd0, game_if.score}, 8'd1);
    wait_idle();

    // Round 4: target 15, stop coincides with timeout -> win
    play(4'd15, 4'd15, 1'b1, 4'd2);
    game_if.target = 4'd9;
    game_if.go = 1'b1;
    step();
    game_if.go = 1'b0;
    game_if.stop = 1'b1;
    step();
    game_if.stop = 1'b0;
    step();
    check_eq("r4_ignore_score", {4'd0, game_if.score}, 8'd2);
    check_eq("r4_ignore_state", {6'd0, game_if.run_led, game_if.time_rst}, 8'd0);
    wait_idle();
    play(4'd9, 4'd9, 1'b1, 4'd3);
    wait_idle();

    // Saturation
    exp_score = 3;
    for (int i = 0; i < 16; i++) begin
      exp_score = (exp_score == 15) ? 15 : exp_score + 1;
      play(4'd0, 4'd0, 1'b1, 4'(exp_score));
      wait_idle();
    end

    // Reset, build score 7, then async reset mid-RUN
    @(negedge clk);
    rst_n = 1'b0;
    qcnt = 2'd0;
    sec = 4'd0;
    game_if.time_bits = 4'd0;
    #1;
    check_reset_outputs("rst2");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 7; i++) begin
      play(4'd0, 4'd0, 1'b1, 4'(i + 1));
      wait_idle();
    end
    game_if.target = 4'd12;
    press_go();
    for (int i = 0; i < 3; i++) step();
    check_eq("mid_run", {7'd0, game_if.run_led}, 8'd1);
    check_eq("mid_score", {4'd0, game_if.score}, 8'd7);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_run", {7'd0, game_if.run_led}, 8'd0);
    check_eq("async_score", {4'd0, game_if.score}, 8'd0);
    check_eq("async_trst", {7'd0, game_if.time_rst}, 8'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reaction_game_ctrl.md
Name: reaction_game_ctrl

Overview:
- Downstream consumer of the quarter-second time counter; drives that counter's synchronous reset/load input.
- Implements a "stop at target second" game:
  - player sets a 4-bit target second and presses go;
  - the counter runs from 0;
  - player presses stop;
  - an exact match on the seconds value wins and increments a saturating score.
- Result is shown with flashing LEDs for a fixed hold time, then the block returns to idle.

Parameters:
- HOLD_SEC, 2, seconds (time_bits value) the WIN/LOSE result is displayed before returning to IDLE; legal 1..15.
- TIMEOUT_SEC, 15, time_bits value in RUN that forces LOSE if no stop arrives; legal 1..15.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- qsec  input  1  one-cycle quarter-second strobe (same strobe feeding the time counter)
- go  input  1  start button, already synchronised/debounced, level
- stop  input  1  stop button, already synchronised/debounced, level
- target  input  4  target second from switches
- time_bits  input  4  seconds value from the time counter (saturates at 15)
- time_rst  output  1  registered; drives time counter load (1 = hold/clear to 0)
- run_led  output  1  high while in RUN
- win_led  output  1  flashing in WIN
- lose_led  output  1  flashing in LOSE
- score  output  4  win count, saturating at 15
- last_time  output  4  time_bits captured at end of last round

Behaviour:
Reset (rst_n low, async):
- state = IDLE; time_rst = 1; score = 0; last_time = 0; target_q = 0; blink = 1; armed = 0.
- All LEDs 0.
- go_d and stop_d reset to 1, so a button held through reset produces no edge.

Edges:
- go_rise = go & ~go_d; stop_rise = stop & ~stop_d.
- go_d/stop_d are registered every clk.

FSM states: IDLE, RUN, WIN, LOSE.

IDLE:
- time_rst = 1 (level); counter held at 0.
- stop_rise ignored.
- go_rise → RUN next cycle; target_q <= target; time_rst <= 0.
- target changes after capture have no effect until the next round.

RUN:
- run_led = 1.
- go_rise ignored (no restart).
- stop_rise:
  - last_time <= time_bits.
  - time_bits == target_q → WIN; score <= score + 1, saturating at 15 (15 stays 15).
  - otherwise → LOSE.
- No stop_rise and time_bits == TIMEOUT_SEC → LOSE; last_time <= TIMEOUT_SEC.
- stop_rise in the same cycle as timeout: stop takes priority and is judged on the current time_bits. A target equal to TIMEOUT_SEC can therefore still win.

Entry into WIN or LOSE:
- time_rst = 1 for exactly the first cycle in the state, then 0.
- armed = 0 in the first cycle, set to 1 in the second.
- blink <= 1 on entry.

WIN/LOSE:
- blink toggles on each qsec.
- win_led = (state==WIN) & blink; lose_led = (state==LOSE) & blink.
- Exit to IDLE when armed & (time_bits >= HOLD_SEC).
- The first cycle is excluded because time_bits still carries the stale RUN value (e.g. 15) until the counter clear takes effect.
- go_rise and stop_rise are ignored.
- On return to IDLE, time_rst goes 1 in the first IDLE cycle.

Other rules:
- score and last_time change only on the transitions above; they persist across rounds and are cleared only by rst_n.
- Async reset asserted mid-RUN, mid-WIN or mid-LOSE: immediate return to reset values, including score.
- Latency: go_rise (cycle n) → run_led = 1 and time_rst = 0 at n+1. stop_rise (cycle n) → win_led or lose_led = 1, time_rst = 1 and score updated at n+1.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.

Test Plan:
- Reset with go held high, then release/re-press → no RUN until a fresh 0→1 on go; after reset all outputs are 0 except time_rst = 1.
- target = 5, go, model counter to time_bits = 5, stop → WIN next cycle; score 0→1; last_time = 5; time_rst pulses 1 cycle; win_led toggles on each qsec; IDLE once time_bits reaches 2.
- target = 5, stop at time_bits = 4 → LOSE; score unchanged; last_time = 4.
- target = 3, no stop, counter reaches 15 → LOSE, last_time = 15. Repeat with target = 15 and stop in the same cycle time_bits hits 15 → WIN.
- Score saturation: 16 consecutive wins → score stays 15. Change target and press go/stop during WIN → no effect; next round uses the new target captured at go.
- Assert rst_n low mid-RUN with score = 7 → state IDLE, score = 0, run_led = 0, time_rst = 1 immediately (asynchronous, before the next clk edge).
